fetch_unit: RTL and testbench

Instruction fetch unit for the 16-bit datapath. It reads the program counter register's output and computes the value driven back into the PC register's input. It issues reads to instruction memory over a req/ack handshake and holds fetched instructions in a small buffer for decode. It also handles branch redirects by flushing in-flight and buffered instructions.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_buffer.sv | 49 ++++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit and its buffer.
package fetch_unit_pkg;

  localparam int FETCH_WIDTH  = 16;
  localparam int FETCH_PC_INC = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WAIT_DROP
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0] instr;
    logic [FETCH_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Instruction buffer between fetch and decode: DEPTH-entry FIFO with flush.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output fetch_entry_t             head_entry
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Flush drops everything, taking priority over a same-cycle push or pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head_valid = (count != '0);
  assign head_entry = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: request FSM toward instruction memory, PC next-value mux,
// and the decode-side instruction buffer.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no request outstanding
//   WAIT      | request outstanding, response will be buffered
//   WAIT_DROP | request outstanding, response discarded (redirect seen)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH  = FETCH_WIDTH,
  parameter int DEPTH  = 2,
  parameter int PC_INC = FETCH_PC_INC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_cur,
  output logic [WIDTH-1:0] pc_next,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_data,
  output logic             ir_valid,
  output logic [WIDTH-1:0] ir_data,
  output logic [WIDTH-1:0] ir_pc,
  input  logic             ir_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t   state, state_nxt;
  logic [WIDTH-1:0] addr_q, addr_nxt;
  logic [CW-1:0]  count, count_after;
  logic           push, pop;
  fetch_entry_t   push_entry, head_entry;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
    end
  end

  always_comb begin
    pop         = ir_valid & ir_ready;
    push        = (state == WAIT) && imem_ack && !redirect;
    count_after = count + CW'(push) - CW'(pop);
    push_entry  = '{instr: imem_data, pc: addr_q};

    if (redirect)                        pc_next = redirect_pc;
    else if (state == WAIT && imem_ack)  pc_next = addr_q + WIDTH'(PC_INC);
    else                                 pc_next = pc_cur;

    state_nxt = state;
    addr_nxt  = addr_q;
    case (state)
      IDLE: begin
        if (!redirect && count < CW'(DEPTH)) begin
          state_nxt = WAIT;
          addr_nxt  = pc_cur;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          // Back-to-back request reuses pc_next, which is what the PC latches now.
          if (!redirect && count_after < CW'(DEPTH)) begin
            state_nxt = WAIT;
            addr_nxt  = pc_next;
          end else begin
            state_nxt = IDLE;
          end
        end else if (redirect) begin
          state_nxt = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (imem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign imem_req  = (state != IDLE);
  assign imem_addr = addr_q;

  fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .count      (count),
    .head_valid (ir_valid),
    .head_entry (head_entry)
  );

  assign ir_data = head_entry.instr;
  assign ir_pc   = head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Cycle-table bench for fetch_unit: bench-owned PC register and memory responses,
// with a scoreboard of instructions expected at the decode side.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pc_cur;
  logic [15:0] pc_next;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        ir_valid;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;
  logic        ir_ready;

  always #5 clock = ~clock;

  fetch_unit #(.WIDTH(16), .DEPTH(2), .PC_INC(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc_cur      (pc_cur),
    .pc_next     (pc_next),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .ir_valid    (ir_valid),
    .ir_data     (ir_data),
    .ir_pc       (ir_pc),
    .ir_ready    (ir_ready)
  );

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          redir;
    logic [15:0] rpc;
    bit          ack;
    logic [15:0] data;
    bit          e_req;
    logic [15:0] e_addr;
    logic [15:0] e_pcn;
    bit          e_valid;
  } vec_t;

  vec_t         vecs[$];
  fetch_entry_t sb[$];
  int           n_vec = 0;
  int           n_bad = 0;

  function automatic void add_vec(bit rst, bit rdy, bit redir, logic [15:0] rpc,
                                  bit ack, logic [15:0] data, bit e_req,
                                  logic [15:0] e_addr, logic [15:0] e_pcn, bit e_valid);
    vec_t v;
    v = '{rst, rdy, redir, rpc, ack, data, e_req, e_addr, e_pcn, e_valid};
    vecs.push_back(v);
  endfunction

  task automatic check(string name, int cyc, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  initial begin
    vec_t        v;
    logic [15:0] prev_pcn;
    bit          prev_rst;
    bit          drop;

    //       rst rdy rdr rpc      ack data     req addr     pc_next  valid
    // zero-wait streaming from reset
    add_vec(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    add_vec(0, 1, 0, 16'h0000, 1, 16'hC000, 1, 16'h0000, 16'h0002, 0);
    add_vec(0, 1, 0, 16'h0000, 1, 16'hC002, 1, 16'h0002, 16'h0004, 1);
    add_vec(0, 1, 0, 16'h0000, 1, 16'hC004, 1, 16'h0004, 16'h0006, 1);
    add_vec(0, 1, 0, 16'h0000, 1, 16'hC006, 1, 16'h0006, 16'h0008, 1);
    add_vec(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 16'h0008, 1);
    // decode stalled: buffer fills, requests stop, then drain
    add_vec(0, 0, 0, 16'h0000, 1, 16'h1111, 1, 16'h0008, 16'h000A, 0);
    add_vec(0, 0, 0, 16'h0000, 1, 16'h2222, 1, 16'h000A, 16'h000C, 1);
    add_vec(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h000A, 16'h000C, 1);
    add_vec(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h000A, 16'h000C, 1);
    add_vec(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h000A, 16'h000C, 1);
    add_vec(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h000A, 16'h000C, 1);
    // three-cycle memory latency
    add_vec(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h000C, 16'h000C, 0);
    add_vec(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h000C, 16'h000C, 0);
    add_vec(0, 1, 0, 16'h0000, 1, 16'h3333, 1, 16'h000C, 16'h000E, 0);
    // redirect while waiting: pending response dropped, buffer flushed
    add_vec(0, 1, 1, 16'h0040, 0, 16'h0000, 1, 16'h000E, 16'h0040, 1);
    add_vec(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h000E, 16'h0040, 0);
    add_vec(0, 1, 0, 16'h0000, 1, 16'hDEAD, 1, 16'h000E, 16'h0040, 0);
    add_vec(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h000E, 16'h0040, 0);
    add_vec(0, 1, 0, 16'h0000, 1, 16'h4040, 1, 16'h0040, 16'h0042, 0);
    // redirect coincident with ack, then redirect while idle
    add_vec(0, 1, 1, 16'hFFFE, 1, 16'hBAD1, 1, 16'h0042, 16'hFFFE, 1);
    add_vec(0, 1, 1, 16'hFFFE, 0, 16'h0000, 0, 16'h0042, 16'hFFFE, 0);
    add_vec(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0042, 16'hFFFE, 0);
    // address wrap at top of memory
    add_vec(0, 1, 0, 16'h0000, 1, 16'h5555, 1, 16'hFFFE, 16'h0000, 0);
    // reset mid-request
    add_vec(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 1);
    add_vec(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
    add_vec(0, 1, 0, 16'h0000, 1, 16'h6666, 1, 16'h0000, 16'h0002, 0);
    add_vec(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 16'h0002, 1);

    reset       = 1'b1;
    pc_cur      = 16'h0000;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    imem_ack    = 1'b0;
    imem_data   = 16'h0000;
    ir_ready    = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_imem_req",  -1, 16'(imem_req), 16'h0000);
    check("reset_imem_addr", -1, imem_addr,     16'h0000);
    check("reset_ir_valid",  -1, 16'(ir_valid), 16'h0000);
    check("reset_ir_data",   -1, ir_data,       16'h0000);
    check("reset_ir_pc",     -1, ir_pc,         16'h0000);
    check("reset_pc_next",   -1, pc_next,       16'h0000);

    prev_pcn = 16'h0000;
    prev_rst = 1'b1;
    drop     = 1'b0;
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      @(posedge clock);
      #1;
      pc_cur      = prev_rst ? 16'h0000 : prev_pcn;
      reset       = v.rst;
      ir_ready    = v.rdy;
      redirect    = v.redir;
      redirect_pc = v.rpc;
      imem_ack    = v.ack;
      imem_data   = v.data;
      @(negedge clock);

      check("imem_req",  k, 16'(imem_req), 16'(v.e_req));
      check("imem_addr", k, imem_addr,     v.e_addr);
      check("pc_next",   k, pc_next,       v.e_pcn);
      check("ir_valid",  k, 16'(ir_valid), 16'(v.e_valid));

      if (v.e_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL scoreboard cycle %0d: got ir_pc %h with nothing expected", k, ir_pc);
        end else begin
          check("ir_data", k, ir_data, sb[0].instr);
          check("ir_pc",   k, ir_pc,   sb[0].pc);
          if (v.rdy) void'(sb.pop_front());
        end
      end
      if (v.redir || v.rst) sb.delete();
      if (v.ack && v.e_req && !v.redir && !drop && !v.rst)
        sb.push_back('{instr: v.data, pc: v.e_addr});

      if (v.rst || v.ack)         drop = 1'b0;
      else if (v.redir && v.e_req) drop = 1'b1;
      prev_pcn = v.e_pcn;
      prev_rst = v.rst;
    end

    check("sb_leftover", vecs.size(), 16'(sb.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
